// File: rtl/piso_tx8_if.sv
// Parallel-side handshake and serial-side outputs of the piso_tx8 transmitter.
interface piso_tx8_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] d;
   logic             load;
   logic             ready;
   logic             sout;
   logic             sout_valid;
   logic             last;
   logic             busy;

   // Producer side: supplies words, observes the serial stream.
   modport master (
      output d, load,
      input  ready, sout, sout_valid, last, busy
   );

   // Transmitter side.
   modport slave (
      input  d, load,
      output ready, sout, sout_valid, last, busy
   );
endinterface

// File: rtl/piso_tx8.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a
// valid/ready handshake and emits it one bit per DIV clock cycles.
module piso_tx8 #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter int DIV       = 1
) (
   input logic       clk,
   input logic       rst,
   piso_tx8_if.slave bus
);
   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [BCW-1:0]   r_bcnt;
   logic [DCW-1:0]   r_dcnt;
   logic             r_sout;
   logic             r_valid;
   logic             r_last;
   logic             r_busy;

   logic             w_bit_end;
   logic             w_word_end;
   logic             w_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_shift_nxt;
   logic             w_first_bit;
   logic             w_next_bit;

   // Terminal counts, handshake and next shift-register contents.
   always_comb begin
      w_bit_end   = (r_dcnt == DCW'(DIV - 1));
      w_word_end  = (r_state == SHIFT) && w_bit_end && (r_bcnt == BCW'(WIDTH - 1));
      w_ready     = (r_state == IDLE) || w_word_end;
      w_accept    = bus.load && w_ready;
      w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                     : {1'b0, r_shift[WIDTH-1:1]};
      w_first_bit = (MSB_FIRST != 0) ? bus.d[WIDTH-1] : bus.d[0];
      w_next_bit  = (MSB_FIRST != 0) ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];
   end

   // FSM with registered serial outputs; sout mirrors the leading bit of r_shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_bcnt  <= '0;
         r_dcnt  <= '0;
         r_sout  <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
      end else if (w_accept) begin
         r_state <= SHIFT;
         r_shift <= bus.d;
         r_bcnt  <= '0;
         r_dcnt  <= '0;
         r_sout  <= w_first_bit;
         r_valid <= 1'b1;
         r_last  <= 1'b0;
         r_busy  <= 1'b1;
      end else if (r_state == SHIFT) begin
         if (w_word_end) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_dcnt  <= '0;
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
         end else if (w_bit_end) begin
            r_shift <= w_shift_nxt;
            r_bcnt  <= r_bcnt + BCW'(1);
            r_dcnt  <= '0;
            r_sout  <= w_next_bit;
            r_last  <= (r_bcnt == BCW'(WIDTH - 2));
         end else begin
            r_dcnt  <= r_dcnt + DCW'(1);
         end
      end
   end

   assign bus.ready      = w_ready;
   assign bus.sout       = r_sout;
   assign bus.sout_valid = r_valid;
   assign bus.last       = r_last;
   assign bus.busy       = r_busy;
endmodule

// File: tb/tb_piso_tx8.sv
// Testbench for piso_tx8: three configurations (MSB-first, LSB-first,
// DIV=3) side by side, checked against a word/position reference model.
module tb_piso_tx8;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] d_a    [3];
   logic       load_a [3];
   logic       ready_a[3];
   logic       sout_a [3];
   logic       valid_a[3];
   logic       last_a [3];
   logic       busy_a [3];

   int checks = 0;
   int errors = 0;

   int msb_of[3] = '{1, 0, 1};
   int div_of[3] = '{1, 1, 3};

   // Reference model: a word in flight and the cycle index within it.
   logic       m_act [3];
   logic [7:0] m_word[3];
   int         m_k   [3];

   always #5 clk = ~clk;

   genvar g;
   for (g = 0; g < 3; g++) begin : gen_dut
      localparam int P_MSB = (g == 1) ? 0 : 1;
      localparam int P_DIV = (g == 2) ? 3 : 1;
      piso_tx8_if #(.WIDTH(8)) bus();
      assign bus.d      = d_a[g];
      assign bus.load   = load_a[g];
      assign ready_a[g] = bus.ready;
      assign sout_a[g]  = bus.sout;
      assign valid_a[g] = bus.sout_valid;
      assign last_a[g]  = bus.last;
      assign busy_a[g]  = bus.busy;
      piso_tx8 #(.WIDTH(8), .MSB_FIRST(P_MSB), .DIV(P_DIV)) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus.slave)
      );
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic m_ready(int i);
      return !m_act[i] || (m_k[i] == 8 * div_of[i] - 1);
   endfunction

   task automatic model_check(int i);
      int   idx;
      logic eb;
      idx = m_k[i] / div_of[i];
      eb  = (msb_of[i] != 0) ? m_word[i][7 - idx] : m_word[i][idx];
      chk($sformatf("m%0d sout", i),  32'(sout_a[i]),  32'(m_act[i] ? eb : 1'b0));
      chk($sformatf("m%0d valid", i), 32'(valid_a[i]), 32'(m_act[i]));
      chk($sformatf("m%0d last", i),  32'(last_a[i]),  32'(m_act[i] && idx == 7));
      chk($sformatf("m%0d busy", i),  32'(busy_a[i]),  32'(m_act[i]));
      chk($sformatf("m%0d ready", i), 32'(ready_a[i]), 32'(m_ready(i)));
   endtask

   // One clock: decide acceptance from pre-edge state, advance model, check.
   task automatic step();
      logic acc[3];
      for (int i = 0; i < 3; i++) acc[i] = load_a[i] && m_ready(i) && !rst;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (acc[i]) begin
            m_act[i]  = 1'b1;
            m_word[i] = d_a[i];
            m_k[i]    = 0;
         end else if (m_act[i]) begin
            if (m_k[i] == 8 * div_of[i] - 1) m_act[i] = 1'b0;
            else m_k[i]++;
         end
      end
      #1;
      for (int i = 0; i < 3; i++) model_check(i);
   endtask

   task automatic check_idle(int i, string nm);
      chk({nm, " sout"},  32'(sout_a[i]),  32'(0));
      chk({nm, " valid"}, 32'(valid_a[i]), 32'(0));
      chk({nm, " last"},  32'(last_a[i]),  32'(0));
      chk({nm, " busy"},  32'(busy_a[i]),  32'(0));
      chk({nm, " ready"}, 32'(ready_a[i]), 32'(1));
   endtask

   typedef struct {
      int         inst;
      logic [7:0] d;
      logic [7:0] bits;   // expected serial bits, first-sent in bit 7
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: timeout reached, expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] b2b;
      logic [7:0]  exp;
      int          n;

      for (int i = 0; i < 3; i++) begin
         d_a[i] = '0; load_a[i] = 1'b0;
         m_act[i] = 1'b0; m_word[i] = '0; m_k[i] = 0;
      end

      vecs[0] = '{0, 8'hC1, 8'b1100_0001};
      vecs[1] = '{1, 8'hC1, 8'b1000_0011};
      vecs[2] = '{0, 8'h0F, 8'b0000_1111};
      vecs[3] = '{1, 8'h0F, 8'b1111_0000};
      vecs[4] = '{2, 8'hC1, 8'b1100_0001};
      vecs[5] = '{2, 8'h5A, 8'b0101_1010};

      // Reset state, held across edges.
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) check_idle(i, $sformatf("rst%0d", i));
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) check_idle(i, $sformatf("rsth%0d", i));
      rst = 1'b0;
      step();

      // Table-driven single words.
      for (int v = 0; v < 6; v++) begin
         int i;
         int dv;
         i  = vecs[v].inst;
         dv = div_of[i];
         d_a[i] = vecs[v].d; load_a[i] = 1'b1;
         step();
         load_a[i] = 1'b0; d_a[i] = ~vecs[v].d;
         for (int c = 0; c < 8 * dv; c++) begin
            chk($sformatf("v%0d sout c%0d", v, c + 1),  32'(sout_a[i]),  32'(vecs[v].bits[7 - c / dv]));
            chk($sformatf("v%0d valid c%0d", v, c + 1), 32'(valid_a[i]), 32'(1));
            chk($sformatf("v%0d last c%0d", v, c + 1),  32'(last_a[i]),  32'(c / dv == 7));
            chk($sformatf("v%0d ready c%0d", v, c + 1), 32'(ready_a[i]), 32'(c == 8 * dv - 1));
            step();
         end
         check_idle(i, $sformatf("v%0d end", v));
      end

      // Back-to-back words with no gap.
      b2b = 16'hC10F;
      d_a[0] = 8'hC1; load_a[0] = 1'b1;
      step();
      load_a[0] = 1'b0;
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("b2b sout c%0d", c + 1),  32'(sout_a[0]),  32'(b2b[15 - c]));
         chk($sformatf("b2b valid c%0d", c + 1), 32'(valid_a[0]), 32'(1));
         chk($sformatf("b2b busy c%0d", c + 1),  32'(busy_a[0]),  32'(1));
         chk($sformatf("b2b last c%0d", c + 1),  32'(last_a[0]),  32'(c == 7 || c == 15));
         if (c == 7) begin d_a[0] = 8'h0F; load_a[0] = 1'b1; end
         else load_a[0] = 1'b0;
         step();
      end
      check_idle(0, "b2b end");

      // Load while busy is ignored.
      exp = 8'hC1;
      d_a[0] = 8'hC1; load_a[0] = 1'b1;
      step();
      load_a[0] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("ign sout c%0d", c + 1), 32'(sout_a[0]), 32'(exp[7 - c]));
         if (c == 3) begin d_a[0] = 8'hFF; load_a[0] = 1'b1; end
         else load_a[0] = 1'b0;
         step();
      end
      check_idle(0, "ign c9");

      // Reset mid-word, then a fresh word.
      d_a[0] = 8'hC1; load_a[0] = 1'b1;
      step();
      load_a[0] = 1'b0;
      for (int c = 0; c < 4; c++) step();
      chk("pre-rst busy", 32'(busy_a[0]), 32'(1));
      #2 rst = 1'b1;
      #1;
      check_idle(0, "rst mid");
      for (int i = 0; i < 3; i++) m_act[i] = 1'b0;
      step();
      rst = 1'b0;
      exp = 8'h0F;
      d_a[0] = 8'h0F; load_a[0] = 1'b1;
      step();
      load_a[0] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("post-rst sout c%0d", c + 1), 32'(sout_a[0]), 32'(exp[7 - c]));
         chk($sformatf("post-rst last c%0d", c + 1), 32'(last_a[0]), 32'(c == 7));
         step();
      end
      check_idle(0, "post-rst end");

      // Randomized traffic on all three configurations.
      n = 400;
      for (int t = 0; t < n; t++) begin
         for (int i = 0; i < 3; i++) begin
            load_a[i] = ($urandom_range(0, 3) != 0);
            d_a[i]    = 8'($urandom);
         end
         step();
      end
      for (int i = 0; i < 3; i++) load_a[i] = 1'b0;
      for (int t = 0; t < 30; t++) step();
      for (int i = 0; i < 3; i++) check_idle(i, $sformatf("drain%0d", i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
